// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for IF/MEM requesters with stall and watchdog
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic [DW-1:0] i_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_stall_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t        state_q, state_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    assign mem_stall_o = (i_req_i & ~i_done_q) | (d_req_i & ~d_done_q);
    assign err_o       = err_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    always_comb begin
        state_d   = state_q;
        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        // Pipeline advances on this edge: both requesters consume their results.
        if (!mem_stall_o) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (d_req_i && !d_done_q) begin
                    req_d   = 1'b1;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    wcnt_d  = 16'd0;
                    state_d = D_WAIT;
                end else if (i_req_i && !i_done_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = i_addr_i;
                    wcnt_d  = 16'd0;
                    state_d = I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                if (mem_ack_i) begin
                    if (state_q == I_WAIT) begin
                        i_rdata_d = mem_rdata_i;
                        i_done_d  = 1'b1;
                    end else begin
                        if (!we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                        d_done_d = 1'b1;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wcnt_q == TMO_LAST) begin
                    // Watchdog abort: report zero data so the pipeline can move on.
                    err_d = 1'b1;
                    if (state_q == I_WAIT) begin
                        i_rdata_d = '0;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            wcnt_q    <= 16'd0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage).
- Serialises the two requests, with data having priority over fetch.
- Holds returned data until both requesters are satisfied, and drives the pipeline-wide memory stall that freezes the IF/ID and later pipeline registers.
- Contains a watchdog that aborts a memory transaction which never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TMO, 255, maximum wait cycles per transaction before abort (1..2^16-1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- i_req_i  in  1  fetch request; held high until the stall clears.
- i_addr_i  in  AW  fetch address; stable while i_req_i is high.
- i_rdata_o  out  DW  fetched word.
- d_req_i  in  1  data request; held high until the stall clears.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  AW  data address.
- d_wdata_i  in  DW  write data.
- d_rdata_o  out  DW  read data.
- mem_stall_o  out  1  pipeline stall (combinational).
- err_o  out  1  sticky timeout flag.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_ack_i  in  1  memory acknowledge; rdata valid in the same cycle.
- mem_rdata_i  in  DW  memory read data.

Behaviour:
- State machine: IDLE, I_WAIT, D_WAIT.
- Internal flags i_done and d_done; internal wait counter wcnt of 16 bits.
- Reset (rst_i=1 at an edge, including mid-transaction):
  - state=IDLE; i_done=d_done=0; wcnt=0; err_o=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - i_rdata_o=0, d_rdata_o=0.
  - mem_stall_o then follows its equation with done=0.
- mem_stall_o = (i_req_i & ~i_done) | (d_req_i & ~d_done).
- IDLE:
  - If d_req_i & ~d_done: register the d address, we and wdata onto the mem_* outputs, set mem_req_o=1, wcnt=0, go to D_WAIT.
  - Else if i_req_i & ~i_done: register i_addr_i, mem_we_o=0, mem_req_o=1, go to I_WAIT.
  - Data has fixed priority over fetch.
- x_WAIT:
  - mem_* outputs stay stable until the transaction ends.
  - On mem_ack_i:
    - capture mem_rdata_i into the matching rdata output (d_rdata_o keeps its old value on a write);
    - set the matching done flag;
    - mem_req_o=0, mem_we_o=0;
    - go to IDLE.
  - Otherwise wcnt+1. When wcnt reaches TMO-1 without ack:
    - err_o=1;
    - matching rdata output = 0;
    - matching done flag set;
    - mem_req_o=0;
    - go to IDLE.
- Done clear: on any edge where mem_stall_o=0 (pipeline advances), both done flags are cleared. This is decoupled from state. A requester that drops its req early leaves a stale done flag; that flag is cleared by the same rule.
- Rdata hold: i_rdata_o and d_rdata_o hold their values until overwritten by the next capture. They remain valid across the cycle where mem_stall_o falls.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req_o high from cycle 1.
  - Ack in cycle k → done and rdata at k+1, stall low at k+1 (if nothing else is pending).
  - Minimum stall is 2 cycles per access.
  - With both requests pending: D completes first, the IDLE bubble follows, then I. Stall stays high until I completes.
- Write transactions: mem_we_o=1 with address and data for the whole D_WAIT. An ack completes the write.
- err_o is cleared only by reset. Operation continues normally after a timeout.
- mem_ack_i in IDLE is ignored.

Test Plan:
- Reset: hold rst_i 2 cycles mid-D_WAIT, then release with no requests → mem_req_o=0, mem_stall_o=0, err_o=0, rdata outputs=0.
- Single fetch:
  - Stimulus: i_req_i=1, addr=0x100; memory acks 1 cycle after mem_req_o with rdata=0xDEADBEEF.
  - Required: mem_addr_o=0x100, mem_we_o=0, stall high for 3 cycles, i_rdata_o=0xDEADBEEF when stall falls.
- Simultaneous:
  - Stimulus: i_req 0x200 and d_req read 0x8000 in the same cycle; zero-wait acks.
  - Required: first mem_addr_o=0x8000, then 0x200; d_rdata_o held through the I transaction; stall falls only after the I capture; done flags clear the next edge.
- Data write:
  - Stimulus: d_we_i=1, addr=0x44, wdata=0x12345678; ack after 3 cycles.
  - Required: mem_we_o/mem_addr_o/mem_wdata_o stable for all 4 request cycles; d_rdata_o unchanged.
- Timeout:
  - Stimulus: TMO=4, no ack.
  - Required: mem_req_o drops after 4 wait cycles, err_o=1, i_rdata_o=0, stall falls.
  - A following request with a normal ack completes; err_o stays 1.
- Back-to-back fetch:
  - Stimulus: a new i_addr_i presented in the cycle after the stall falls.
  - Required: a new transaction is issued; the stale done flag does not suppress it.
